// File: rtl/tt_um_cedrichirschi_sar.sv
// ---------------------------------------------------------------------------
// tt_um_cedrichirschi_sar
//   Successive-approximation ADC controller for a Tiny Tapeout tile.
//   It drives an external DAC on uio_out and reads an external comparator on
//   ui_in[0]. It then binary-searches the input voltage one bit per trial.
//   Each trial lasts SETTLE_CYCLES clocks. The finished code appears on uo_out.
//
//   Optional feature macro: SAR_CONTINUOUS_EN
//     When the macro is defined and ui_in[3]=1 at completion, the same edge
//     also loads the next MSB trial. This gives back-to-back conversions.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : synchronous reset, active-low
//   ena     : tile enable; 0 aborts a running conversion / blocks start
//   ui_in   : [0] comparator (1 = Vin >= Vdac), [1] start, [2] status view,
//             [3] continuous mode (SAR_CONTINUOUS_EN only), [7:4] unused
//   uo_out  : result, or {busy, done, 3'b0, bit_idx} when ui_in[2]=1
//   uio_in  : unused
//   uio_out : DAC code (trial code while busy, last result while idle)
//   uio_oe  : all ones
// ---------------------------------------------------------------------------
module tt_um_cedrichirschi_sar #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CODE_MSB = WIDTH'(1) << (WIDTH - 1);
  localparam logic [2:0]       IDX_MSB  = 3'(WIDTH - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state;
  logic [WIDTH-1:0] code;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             comp_q1;
  logic             comp_s;
  logic             start_q;

  logic             start_rise;
  logic             cont_mode;
  logic [WIDTH-1:0] code_keep;
  logic [WIDTH-1:0] code_next;
  logic [7:0]       result_ext;
  logic [7:0]       code_ext;

  assign start_rise = ui_in[1] & ~start_q;

`ifdef SAR_CONTINUOUS_EN
  assign cont_mode = ui_in[3];
`else
  assign cont_mode = 1'b0;
`endif

  // code_keep: current trial bit resolved by the comparator.
  // code_next: code_keep with the next lower trial bit set.
  always_comb begin
    code_keep = code;
    if (!comp_s) code_keep[bit_idx] = 1'b0;
    code_next = code_keep;
    if (bit_idx != 3'd0) code_next[bit_idx - 3'd1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      code    <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      bit_idx <= 3'd0;
      cnt     <= '0;
      comp_q1 <= 1'b0;
      comp_s  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      comp_q1 <= ui_in[0];
      comp_s  <= comp_q1;
      start_q <= ui_in[1];
      case (state)
        IDLE: begin
          if (ena && start_rise) begin
            state   <= CONV;
            busy    <= 1'b1;
            done    <= 1'b0;
            code    <= CODE_MSB;
            bit_idx <= IDX_MSB;
            cnt     <= '0;
          end
        end
        CONV: begin
          if (!ena) begin
            // Abort: the DAC falls back to the last good result.
            state <= IDLE;
            busy  <= 1'b0;
            code  <= result;
            cnt   <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (bit_idx != 3'd0) begin
              code    <= code_next;
              bit_idx <= bit_idx - 3'd1;
            end else begin
              result <= code_keep;
              done   <= 1'b1;
              if (cont_mode) begin
                code    <= CODE_MSB;
                bit_idx <= IDX_MSB;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                code  <= code_keep;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    result_ext             = 8'h00;
    result_ext[WIDTH-1:0]  = result;
    code_ext               = 8'h00;
    code_ext[WIDTH-1:0]    = code;
  end

  assign uo_out  = ui_in[2] ? {busy, done, 3'b000, bit_idx} : result_ext;
  assign uio_out = code_ext;
  assign uio_oe  = 8'hFF;

  logic unused;
  assign unused = &{1'b0, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_tt_um_cedrichirschi_sar.sv
module tb_tt_um_cedrichirschi_sar;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] vin = 8'h00;
  logic       start = 1'b0;
  logic       view = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Ideal comparator looking at the DAC code.
  assign ui_in = {4'b0000, cont, view, start, (vin >= uio_out)};

  tt_um_cedrichirschi_sar dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  // Returns at the falling edge just after the edge that accepts start.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges with busy high, starting at the current one.
  task automatic count_busy(output int n);
    logic v;
    v = view;
    view = 1'b1;
    #1;
    n = 0;
    while (uo_out[7] && n < 100) begin
      n++;
      @(negedge clk);
    end
    view = v;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vin = 8'h77;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    view = 1'b0;
    #1;
    checks++; if (uo_out !== 8'h00) $display("FAIL reset_uo got %h want 00", uo_out); else passed++;
    checks++; if (uio_out !== 8'h00) $display("FAIL reset_uio got %h want 00", uio_out); else passed++;
    checks++; if (uio_oe !== 8'hFF) $display("FAIL reset_oe got %h want FF", uio_oe); else passed++;
    view = 1'b1;
    #1;
    checks++; if (uo_out !== 8'h00) $display("FAIL reset_status got %h want 00", uo_out); else passed++;
    view = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    logic [7:0] e;
    vin = 8'hA5;
    exp_q.push_back(8'hA5);
    pulse_start();
    #1;
    checks++; if (uio_out !== 8'h80) $display("FAIL basic_trial got %h want 80", uio_out); else passed++;
    count_busy(n);
    checks++; if (n != 32) $display("FAIL basic_busy_cycles got %0d want 32", n); else passed++;
    view = 1'b1;
    #1;
    checks++; if (uo_out !== 8'h40) $display("FAIL basic_status got %h want 40", uo_out); else passed++;
    view = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++; if (uo_out !== e) $display("FAIL basic_result got %h want %h", uo_out, e); else passed++;
    checks++; if (uio_out !== e) $display("FAIL basic_dac_idle got %h want %h", uio_out, e); else passed++;
  endtask

  task automatic test_extremes();
    int n;
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      vin = (k == 0) ? 8'h00 : 8'hFF;
      exp_q.push_back(vin);
      pulse_start();
      #1;
      checks++; if (uio_out !== 8'h80) $display("FAIL extreme_trial%0d got %h want 80", k, uio_out); else passed++;
      count_busy(n);
      e = exp_q.pop_front();
      checks++; if (n != 32) $display("FAIL extreme_busy%0d got %0d want 32", k, n); else passed++;
      checks++; if (uo_out !== e) $display("FAIL extreme_result%0d got %h want %h", k, uo_out, e); else passed++;
    end
  endtask

  task automatic test_held_start();
    int n;
    int extra;
    logic [7:0] e;
    vin = 8'h5A;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    view = 1'b1;
    #1;
    n = 0;
    while (uo_out[7] && n < 100) begin
      n++;
      if (n == 10) start = 1'b0;
      if (n == 11) start = 1'b1;
      @(negedge clk);
      #1;
    end
    checks++; if (n != 32) $display("FAIL held_busy got %0d want 32", n); else passed++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (uo_out[7]) extra++;
    end
    checks++; if (extra != 0) $display("FAIL held_second_conv busy_cycles %0d want 0", extra); else passed++;
    start = 1'b0;
    view = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++; if (uo_out !== e) $display("FAIL held_result got %h want %h", uo_out, e); else passed++;
  endtask

  task automatic test_abort();
    vin = 8'h33;
    pulse_start();
    repeat (11) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    view = 1'b1;
    #1;
    checks++; if (uo_out[7:6] !== 2'b00) $display("FAIL abort_busy_done got %b want 00", uo_out[7:6]); else passed++;
    view = 1'b0;
    #1;
    checks++; if (uo_out !== 8'h5A) $display("FAIL abort_result got %h want 5A", uo_out); else passed++;
    checks++; if (uio_out !== 8'h5A) $display("FAIL abort_dac got %h want 5A", uio_out); else passed++;

    // ena low in IDLE blocks start.
    ena = 1'b0;
    pulse_start();
    @(negedge clk);
    ena = 1'b1;
    view = 1'b1;
    #1;
    checks++; if (uo_out[7] !== 1'b0) $display("FAIL ena_block_busy got %b want 0", uo_out[7]); else passed++;
    view = 1'b0;

    pulse_start();
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (uo_out !== 8'h00) $display("FAIL midreset_result got %h want 00", uo_out); else passed++;
    checks++; if (uio_out !== 8'h00) $display("FAIL midreset_dac got %h want 00", uio_out); else passed++;
    view = 1'b1;
    #1;
    checks++; if (uo_out !== 8'h00) $display("FAIL midreset_status got %h want 00", uo_out); else passed++;
    view = 1'b0;
    @(negedge clk);
  endtask

`ifdef SAR_CONTINUOUS_EN
  task automatic test_continuous();
    logic [7:0] e;
    cont = 1'b1;
    vin = 8'h3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    pulse_start();
    repeat (32) @(negedge clk);
    vin = 8'hC3;
    view = 1'b1;
    #1;
    checks++; if (uo_out[7:6] !== 2'b11) $display("FAIL cont_busy_done got %b want 11", uo_out[7:6]); else passed++;
    view = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++; if (uo_out !== e) $display("FAIL cont_result1 got %h want %h", uo_out, e); else passed++;
    repeat (32) @(negedge clk);
    cont = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++; if (uo_out !== e) $display("FAIL cont_result2 got %h want %h", uo_out, e); else passed++;
    repeat (40) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_held_start();
    test_abort();
`ifdef SAR_CONTINUOUS_EN
    test_continuous();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
